// File: rtl/reg_file_bypass_pkg.sv
// Shared definitions for the integer register file.
// Contents:
//   state_e      - sequencer state: clear sweep in progress, or normal run
//   XLEN_DEF     - default data width
//   ADDR_W_DEF   - default address width (depth = 2**ADDR_W)
//   SP_INIT_DEF  - default value loaded into the stack pointer by the sweep
package reg_file_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  localparam int          XLEN_DEF    = 32;
  localparam int          ADDR_W_DEF  = 5;
  localparam logic [31:0] SP_INIT_DEF = 32'h0101_1111;

endpackage

// File: rtl/reg_file_bypass_read_port.sv
// One combinational read port of the register file.
// Ports:
//   ready     in   file contents valid; while low the port drives zero
//   wr_en     in   writeback-stage write enable (for forwarding)
//   wr_addr   in   writeback-stage write address
//   wr_data   in   writeback-stage write data
//   rd_addr   in   address read by this port
//   mem_rdata in   storage array content at rd_addr
//   rd_data   out  read result
module rf_read_port #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   rd_data
);

  logic fwd_hit;

  generate
    if (BYPASS) begin : g_bypass
      // Forward the in-flight writeback so decode sees it this cycle.
      assign fwd_hit = ready && wr_en && (wr_addr == rd_addr);
    end else begin : g_no_bypass
      assign fwd_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    rd_data = mem_rdata;
    if (!ready || rd_addr == '0) begin
      rd_data = '0;                 // x0 reads zero; nothing valid mid-sweep
    end else if (fwd_hit) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/reg_file_bypass.sv
// Parametrised integer register file for the decode stage.
// Ports:
//   clk        in   system clock, all state on rising edge
//   reset_n    in   synchronous active-low reset
//   rd_addr    in   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    out  packed read data, port k at [k*XLEN +: XLEN]
//   wr_en      in   write enable
//   wr_addr    in   write address
//   wr_data    in   write data
//   clear_req  in   one-cycle pulse: re-run the clear sweep
//   ready      out  file valid and accepting writes
// After reset or clear_req, a sweep writes one register per cycle with its
// init value (SP_INIT at SP_IDX, zero elsewhere) and then raises ready.
module reg_file_bypass
  import reg_file_pkg::*;
#(
  parameter int              XLEN    = XLEN_DEF,
  parameter int              ADDR_W  = ADDR_W_DEF,
  parameter int              NUM_RD  = 2,
  parameter int              SP_IDX  = 2,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF),
  parameter bit              BYPASS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     clear_req,
  output logic                     ready
);

  localparam int                NREGS    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] SP_ADDR  = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  logic [XLEN-1:0] mem [NREGS];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              ready_q, ready_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [XLEN-1:0]   mem_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    case (state_q)
      S_CLEAR: begin
        idx_d = idx_q + 1'b1;
        // Leave before idx wraps, so the last register is the exit condition.
        if (idx_q == LAST_IDX) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end
      end
      S_RUN: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        idx_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Output logic: select the single storage write for this cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = (idx_q == SP_ADDR) ? SP_INIT : '0;
      end
      S_RUN: begin
        // clear_req wins over a simultaneous write; x0 is never stored.
        if (!clear_req && wr_en && wr_addr != '0) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr;
          mem_wdata = wr_data;
        end
      end
      default: mem_we = 1'b0;
    endcase
  end

  // Storage array, no reset: the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign ready = ready_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] port_addr;
      logic [XLEN-1:0]   port_mem;

      assign port_addr = rd_addr[gi*ADDR_W +: ADDR_W];
      assign port_mem  = mem[port_addr];

      rf_read_port #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
      ) u_rd (
        .ready     (ready_q),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (port_addr),
        .mem_rdata (port_mem),
        .rd_data   (rd_data[gi*XLEN +: XLEN])
      );
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_bypass.sv
module tb_reg_file_bypass;

  localparam logic [31:0] SPV = 32'h0101_1111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the BYPASS=1 (a) and BYPASS=0 (b) instances
  logic        reset_n;
  logic [9:0]  rd_addr_ab;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clear_req;
  logic [63:0] rd_data_a, rd_data_b;
  logic        ready_a, ready_b;

  // Wide / shallow / three-port instance (c)
  logic [11:0]  rd_addr_c;
  logic         wr_en_c;
  logic [3:0]   wr_addr_c;
  logic [63:0]  wr_data_c;
  logic         clear_req_c;
  logic [191:0] rd_data_c;
  logic         ready_c;

  reg_file_bypass #(.BYPASS(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr_ab), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req), .ready(ready_a));

  reg_file_bypass #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr_ab), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req), .ready(ready_b));

  reg_file_bypass #(.XLEN(64), .ADDR_W(4), .NUM_RD(3)) dut_c (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .clear_req(clear_req_c), .ready(ready_c));

  // Scoreboard
  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;
  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic push_exp(input string n, input logic [63:0] e);
    exp_t x;
    x.name = n;
    x.exp  = e;
    sb_q.push_back(x);
  endtask

  task automatic pop_check(input logic [63:0] act);
    exp_t x;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: got %h with no expectation queued", act);
    end else begin
      x = sb_q.pop_front();
      if (act !== x.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", x.name, act, x.exp);
      end else begin
        $display("ok   %s: %h", x.name, act);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after a sweep starts; ready must rise exactly on edge 32.
  task automatic check_sweep(input string tag);
    for (int e = 1; e <= 32; e++) begin
      tick();
      push_exp($sformatf("%s_ready_e%0d", tag, e), {63'd0, (e == 32)});
      pop_check({63'd0, ready_a});
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r0, r1;
    logic [31:0] ea0, ea1, eb0, eb1;
  } vec_t;
  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  32'h0,          5'd2,  5'd1,  SPV,          32'h0,        SPV,          32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,          5'd3,  5'd31, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[2]  = '{1'b1, 5'd5,  32'hDEAD_BEEF,  5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,       32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,          5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 5'd0,  32'h1234,       5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,          5'd0,  5'd2,  32'h0,        SPV,          32'h0,        SPV};
    vecs[6]  = '{1'b1, 5'd7,  32'hA5A5_A5A5,  5'd3,  5'd7,  32'h0,        32'hA5A5_A5A5, 32'h0,       32'h0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,          5'd7,  5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[8]  = '{1'b1, 5'd9,  32'h111,        5'd9,  5'd10, 32'h111,      32'h0,        32'h0,        32'h0};
    vecs[9]  = '{1'b1, 5'd9,  32'h222,        5'd9,  5'd9,  32'h222,      32'h222,      32'h111,      32'h111};
    vecs[10] = '{1'b0, 5'd0,  32'h0,          5'd9,  5'd5,  32'h222,      32'hDEAD_BEEF, 32'h222,     32'hDEAD_BEEF};

    reset_n = 1'b0; rd_addr_ab = {5'd0, 5'd2}; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; clear_req = 1'b0;
    rd_addr_c = '0; wr_en_c = 1'b0; wr_addr_c = '0; wr_data_c = '0; clear_req_c = 1'b0;

    // Reset state
    repeat (3) tick();
    push_exp("rst_ready", 64'd0);
    pop_check({63'd0, ready_a});
    push_exp("rst_rd_x2", 64'd0);
    pop_check({32'd0, rd_data_a[31:0]});

    // Test 1 + test 6 latency: release reset, count edges
    reset_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      push_exp($sformatf("init_ready_e%0d", e), {63'd0, (e == 32)});
      pop_check({63'd0, ready_a});
      if (e == 15 || e == 16) begin
        push_exp($sformatf("c_ready_e%0d", e), {63'd0, (e == 16)});
        pop_check({63'd0, ready_c});
      end
    end

    // Tests 1-3: table of reads / writes / bypass on both instances
    for (int i = 0; i < 11; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_addr_ab = {vecs[i].r1, vecs[i].r0};
      push_exp($sformatf("vec%0d_a0", i), {32'd0, vecs[i].ea0});
      push_exp($sformatf("vec%0d_a1", i), {32'd0, vecs[i].ea1});
      push_exp($sformatf("vec%0d_b0", i), {32'd0, vecs[i].eb0});
      push_exp($sformatf("vec%0d_b1", i), {32'd0, vecs[i].eb1});
      @(negedge clk);
      pop_check({32'd0, rd_data_a[31:0]});
      pop_check({32'd0, rd_data_a[63:32]});
      pop_check({32'd0, rd_data_b[31:0]});
      pop_check({32'd0, rd_data_b[63:32]});
      tick();
    end
    wr_en = 1'b0;
    push_exp("x0_entry_unchanged", 64'd0);
    pop_check({32'd0, dut_a.mem[0]});

    // Test 6: 64-bit, 3-port instance
    wr_en_c = 1'b1; wr_addr_c = 4'd1;  wr_data_c = 64'h0123_4567_89AB_CDEF; tick();
    wr_addr_c = 4'd6;  wr_data_c = 64'hFEDC_BA98_7654_3210; tick();
    wr_addr_c = 4'd15; wr_data_c = 64'h8000_0000_0000_0001; tick();
    wr_en_c = 1'b0; rd_addr_c = {4'd15, 4'd6, 4'd1};
    push_exp("c_p0_x1",  64'h0123_4567_89AB_CDEF);
    push_exp("c_p1_x6",  64'hFEDC_BA98_7654_3210);
    push_exp("c_p2_x15", 64'h8000_0000_0000_0001);
    @(negedge clk);
    pop_check(rd_data_c[63:0]);
    pop_check(rd_data_c[127:64]);
    pop_check(rd_data_c[191:128]);
    tick();
    wr_en_c = 1'b1; wr_addr_c = 4'd15; wr_data_c = 64'hCAFE_0000_0000_BABE;
    rd_addr_c = {4'd15, 4'd0, 4'd2};
    push_exp("c_p0_sp",  64'h0000_0000_0101_1111);
    push_exp("c_p1_x0",  64'd0);
    push_exp("c_p2_fwd", 64'hCAFE_0000_0000_BABE);
    @(negedge clk);
    pop_check(rd_data_c[63:0]);
    pop_check(rd_data_c[127:64]);
    pop_check(rd_data_c[191:128]);
    tick();
    wr_en_c = 1'b0;

    // Test 4: clear during run, simultaneous write dropped
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h55; tick();
    wr_en = 1'b0; rd_addr_ab = {5'd11, 5'd10};
    push_exp("pre_clear_x10", 64'h55);
    @(negedge clk);
    pop_check({32'd0, rd_data_a[31:0]});
    tick();
    clear_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h77;
    tick();
    clear_req = 1'b0; wr_en = 1'b0;
    push_exp("clear_ready_fell", 64'd0);
    pop_check({63'd0, ready_a});
    check_sweep("clr");
    push_exp("clr_x10", 64'd0);
    push_exp("clr_x11", 64'd0);
    @(negedge clk);
    pop_check({32'd0, rd_data_a[31:0]});
    pop_check({32'd0, rd_data_a[63:32]});
    tick();
    rd_addr_ab = {5'd0, 5'd2};
    push_exp("clr_sp", {32'd0, SPV});
    @(negedge clk);
    pop_check({32'd0, rd_data_a[31:0]});
    tick();

    // Test 5: reset at sweep idx 15, write during sweep ignored
    clear_req = 1'b1; tick();
    clear_req = 1'b0;
    repeat (15) tick();
    reset_n = 1'b0; tick();
    reset_n = 1'b1;
    push_exp("midrst_ready", 64'd0);
    pop_check({63'd0, ready_a});
    for (int e = 1; e <= 32; e++) begin
      if (e == 10) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        rd_addr_ab = {5'd3, 5'd2};
        push_exp("sweep_gate_p0", 64'd0);
        push_exp("sweep_gate_p1", 64'd0);
        @(negedge clk);
        pop_check({32'd0, rd_data_a[31:0]});
        pop_check({32'd0, rd_data_a[63:32]});
      end else begin
        wr_en = 1'b0;
      end
      tick();
      push_exp($sformatf("midrst_ready_e%0d", e), {63'd0, (e == 32)});
      pop_check({63'd0, ready_a});
    end
    wr_en = 1'b0; rd_addr_ab = {5'd2, 5'd3};
    push_exp("midrst_x3", 64'd0);
    push_exp("midrst_sp", {32'd0, SPV});
    @(negedge clk);
    pop_check({32'd0, rd_data_a[31:0]});
    pop_check({32'd0, rd_data_a[63:32]});

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d queued expectations, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_bypass.md
Name: reg_file_bypass

Overview:
Parametrised successor to the CPU integer register file.
- Configurable width, depth and read-port count.
- Register x0 is hardwired to zero.
- Write-to-read bypass in the same cycle.
- After reset, or on a clear request, a sequenced clear sweep restores every register to its init value, with a ready flag for the pipeline.
- Sits in the decode stage: rs1/rs2 (and optional rs3) reads, writeback-stage write.

Parameters:
XLEN, 32, data width in bits
ADDR_W, 5, address width; depth NREGS = 2**ADDR_W
NUM_RD, 2, number of combinational read ports (1..4)
SP_IDX, 2, index of the stack-pointer register
SP_INIT, 32'h0101_1111, value loaded into SP_IDX by the clear sweep
BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = none

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous active-low reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k is bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*XLEN  packed read data, same packing
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  XLEN  write data
clear_req  in  1  one-cycle pulse: re-run the clear sweep
ready  out  1  1 = file valid and accepting writes

Behaviour:
States (shared enum): S_CLEAR, S_RUN.

Reset:
- Any rising edge with reset_n=0 sets state=S_CLEAR, idx=0, ready=0.
- Storage array is not reset directly; the sweep initialises it.
- reset_n asserted mid-sweep restarts the sweep at idx=0.

S_CLEAR, each edge with reset_n=1:
- mem[idx] <= (idx==SP_IDX) ? SP_INIT : 0.
- idx <= idx+1.
- When idx==NREGS-1: state <= S_RUN, ready <= 1.
- idx is ADDR_W bits; the transition occurs before wrap, so no wrap compare is needed.
- Latency: ready rises on the NREGS-th edge after reset_n goes high (32 edges by default).

While ready=0:
- wr_en is ignored (write dropped).
- All rd_data ports drive 0.
- clear_req is ignored.

S_RUN:
- Write: if wr_en && wr_addr!=0, then mem[wr_addr] <= wr_data. A write to address 0 is silently dropped.
- clear_req=1: state <= S_CLEAR, idx <= 0, ready <= 0 at that edge. A simultaneous wr_en in the same cycle is dropped (clear wins).

Reads (combinational, each port independent):
- rd_addr==0 returns 0.
- Else if BYPASS && ready && wr_en && wr_addr==rd_addr, returns wr_data.
- Else returns mem[rd_addr].
- Multiple ports may read the same address.

Other rules:
- No arithmetic beyond the idx increment.
- Widths are exact; no truncation on data paths.

Decomposition:
Package reg_file_pkg holds:
- the state enum (S_CLEAR, S_RUN);
- default constants XLEN_DEF, ADDR_W_DEF, SP_INIT_DEF.

Sub-module rf_read_port (one per read port, via generate) contains:
- the x0 zero,
- the ready gate,
- the bypass compare and mux.

The top module holds the storage array, the FSM and the idx counter.

Test Plan:
1. Release reset_n, hold all inputs idle -> ready=0 for edges 1..31, ready=1 after edge 32. Then reads: rd_addr=2 returns 32'h0101_1111; addresses 1, 3 and 31 return 0.
2. After ready, write x5=32'hDEAD_BEEF, then next cycle read port0=5, port1=5 -> both 32'hDEAD_BEEF. Write x0=32'h1234 -> read x0 returns 0 and array entry 0 is unchanged.
3. Bypass: wr_en=1, wr_addr=7, wr_data=32'hA5A5_A5A5 with rd_addr port1=7 in the same cycle -> rd_data port1=32'hA5A5_A5A5 before the edge. With BYPASS=0 the same stimulus returns the old value (0).
4. Clear during run: set x10=32'h55, pulse clear_req together with wr_en to x11=32'h77 -> ready falls next edge, x11 write is lost, after 32 more edges x10=0, x11=0, x2=SP_INIT.
5. Reset mid-sweep: assert reset_n=0 at sweep idx=15 for 1 cycle, then release -> ready rises exactly 32 edges after release. A wr_en at x3 during the sweep is ignored; x3 reads 0 afterwards.
6. Parameter sweep: XLEN=64, ADDR_W=4, NUM_RD=3 -> ready after 16 edges; three ports read distinct registers written with 64-bit patterns correctly.
